spram_arbiter: RTL and testbench

- Shares one `spram` instance between two requesters: port 0 (core/fetch-load) and port 1 (scan/debug loader).
- Accepts per-port request/grant commands and registers the granted command onto the `spram` pins.
- Routes the 1-cycle-latency read data back to the issuing port with a tag.
- Port 1 has fixed priority; an anti-starvation counter guarantees port 0 forward progress.

---
 rtl/spram_arb_pkg.sv | 30 +++
 rtl/arb_prio_starve.sv | 50 +++++
 rtl/spram_arbiter.sv | 149 ++++++++++++++
 tb/tb_spram_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spram_arb_pkg.sv
// Shared types and constants for the two-port spram arbiter.
// mem_cmd_t is the default-width command layout seen at a requester port.
package spram_arb_pkg;

    localparam int unsigned DEF_WIDTH = 32;
    localparam int unsigned DEF_AW    = 11;

    localparam logic PORT_CORE = 1'b0;
    localparam logic PORT_SCAN = 1'b1;

    typedef struct packed {
        logic                 we;
        logic                 id_sel;
        logic [1:0]           seg_id;
        logic [DEF_AW-1:0]    addr;
        logic [DEF_WIDTH-1:0] wdata;
    } mem_cmd_t;

    // A read occupying S1 pins mem_id_sel for its response cycle, so a
    // candidate aimed at the other bank must wait one cycle.
    function automatic logic bank_conflict(
        input logic s1_valid,
        input logic s1_we,
        input logic s1_id_sel,
        input logic cand_id_sel
    );
        return s1_valid && !s1_we && (s1_id_sel != cand_id_sel);
    endfunction

endpackage

// File: rtl/arb_prio_starve.sv
// Two-way fixed-priority arbiter (scan port wins) with an anti-starvation
// counter that forces the core port through after MAX_WAIT denied cycles.
module arb_prio_starve
    import spram_arb_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       stall,
    input  logic [1:0] req,
    input  logic [1:0] elig,
    output logic [1:0] gnt
);

    localparam int unsigned CW = $clog2(MAX_WAIT + 1);

    logic [CW-1:0] wait_cnt_q;
    logic [CW-1:0] wait_cnt_d;
    logic          force_core;

    always_comb begin
        force_core = (wait_cnt_q == CW'(MAX_WAIT));
        gnt        = '0;
        if (elig[PORT_SCAN] && !(elig[PORT_CORE] && force_core)) begin
            gnt[PORT_SCAN] = 1'b1;
        end else if (elig[PORT_CORE]) begin
            gnt[PORT_CORE] = 1'b1;
        end
    end

    // Denials caused by a bank-conflict bubble still count; only stall freezes.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (gnt[PORT_CORE] || !req[PORT_CORE]) begin
            wait_cnt_d = '0;
        end else if (!stall && !force_core) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

endmodule

// File: rtl/spram_arbiter.sv
// Shares one spram between the core port (0) and the scan/debug port (1):
// grant -> S1 drives the mem pins -> S2 routes read data back to its port.
module spram_arbiter
    import spram_arb_pkg::*;
#(
    parameter int unsigned WIDTH    = DEF_WIDTH,
    parameter int unsigned AW       = DEF_AW,
    parameter int unsigned MAX_WAIT = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,

    input  logic             p0_req,
    input  logic             p0_we,
    input  logic             p0_id_sel,
    input  logic [1:0]       p0_seg_id,
    input  logic [AW-1:0]    p0_addr,
    input  logic [WIDTH-1:0] p0_wdata,
    output logic             p0_gnt,
    output logic             p0_rvalid,
    output logic [WIDTH-1:0] p0_rdata,

    input  logic             p1_req,
    input  logic             p1_we,
    input  logic             p1_id_sel,
    input  logic [1:0]       p1_seg_id,
    input  logic [AW-1:0]    p1_addr,
    input  logic [WIDTH-1:0] p1_wdata,
    output logic             p1_gnt,
    output logic             p1_rvalid,
    output logic [WIDTH-1:0] p1_rdata,

    output logic             mem_cen,
    output logic             mem_wen,
    output logic             mem_ren,
    output logic             mem_id_sel,
    output logic [AW-1:0]    mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic [1:0]       mem_seg_id,
    input  logic [WIDTH-1:0] mem_rdata
);

    typedef struct packed {
        logic             valid;
        logic             port;
        logic             we;
        logic             id_sel;
        logic [1:0]       seg_id;
        logic [AW-1:0]    addr;
        logic [WIDTH-1:0] wdata;
    } s1_t;

    typedef struct packed {
        logic valid;
        logic port;
        logic id_sel;
    } s2_t;

    s1_t        s1_q;
    s1_t        s1_d;
    s2_t        s2_q;
    s2_t        s2_d;
    logic [1:0] req;
    logic [1:0] elig;
    logic [1:0] arb_gnt;

    always_comb begin
        req             = {p1_req, p0_req};
        elig            = '0;
        elig[PORT_CORE] = p0_req && !stall && !rst &&
                          !bank_conflict(s1_q.valid, s1_q.we, s1_q.id_sel, p0_id_sel);
        elig[PORT_SCAN] = p1_req && !stall && !rst &&
                          !bank_conflict(s1_q.valid, s1_q.we, s1_q.id_sel, p1_id_sel);
    end

    arb_prio_starve #(
        .MAX_WAIT (MAX_WAIT)
    ) u_arb (
        .clk   (clk),
        .rst   (rst),
        .stall (stall),
        .req   (req),
        .elig  (elig),
        .gnt   (arb_gnt)
    );

    assign p0_gnt = arb_gnt[PORT_CORE];
    assign p1_gnt = arb_gnt[PORT_SCAN];

    always_comb begin
        s1_d = '0;
        if (arb_gnt[PORT_SCAN]) begin
            s1_d.valid  = 1'b1;
            s1_d.port   = PORT_SCAN;
            s1_d.we     = p1_we;
            s1_d.id_sel = p1_id_sel;
            s1_d.seg_id = p1_seg_id;
            s1_d.addr   = p1_addr;
            s1_d.wdata  = p1_wdata;
        end else if (arb_gnt[PORT_CORE]) begin
            s1_d.valid  = 1'b1;
            s1_d.port   = PORT_CORE;
            s1_d.we     = p0_we;
            s1_d.id_sel = p0_id_sel;
            s1_d.seg_id = p0_seg_id;
            s1_d.addr   = p0_addr;
            s1_d.wdata  = p0_wdata;
        end
    end

    always_comb begin
        s2_d = '0;
        if (s1_q.valid && !s1_q.we) begin
            s2_d.valid  = 1'b1;
            s2_d.port   = s1_q.port;
            s2_d.id_sel = s1_q.id_sel;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    // ren stays high through S2 because spram gates its rdata with ren.
    always_comb begin
        mem_cen    = s1_q.valid || s2_q.valid;
        mem_wen    = s1_q.valid && s1_q.we;
        mem_ren    = (s1_q.valid && !s1_q.we) || s2_q.valid;
        mem_id_sel = s1_q.valid ? s1_q.id_sel : s2_q.id_sel;
        mem_addr   = s1_q.valid ? s1_q.addr   : '0;
        mem_wdata  = s1_q.valid ? s1_q.wdata  : '0;
        mem_seg_id = s1_q.valid ? s1_q.seg_id : '0;
    end

    always_comb begin
        p0_rvalid = s2_q.valid && (s2_q.port == PORT_CORE);
        p1_rvalid = s2_q.valid && (s2_q.port == PORT_SCAN);
        p0_rdata  = p0_rvalid ? mem_rdata : '0;
        p1_rdata  = p1_rvalid ? mem_rdata : '0;
    end

endmodule

// File: tb/tb_spram_arbiter.sv
// Directed scenarios plus a random phase for spram_arbiter, checked each
// cycle against a transaction-level model of grants, pins and read returns.
module tb_spram_arbiter;

    localparam int unsigned WIDTH    = 32;
    localparam int unsigned AW       = 11;
    localparam int unsigned MAX_WAIT = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             stall;
    logic             p0_req, p0_we, p0_id_sel, p0_gnt, p0_rvalid;
    logic [1:0]       p0_seg_id;
    logic [AW-1:0]    p0_addr;
    logic [WIDTH-1:0] p0_wdata, p0_rdata;
    logic             p1_req, p1_we, p1_id_sel, p1_gnt, p1_rvalid;
    logic [1:0]       p1_seg_id;
    logic [AW-1:0]    p1_addr;
    logic [WIDTH-1:0] p1_wdata, p1_rdata;
    logic             mem_cen, mem_wen, mem_ren, mem_id_sel;
    logic [AW-1:0]    mem_addr;
    logic [WIDTH-1:0] mem_wdata, mem_rdata;
    logic [1:0]       mem_seg_id;

    always #5 clk = ~clk;

    spram_arbiter #(
        .WIDTH    (WIDTH),
        .AW       (AW),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .p0_req     (p0_req),
        .p0_we      (p0_we),
        .p0_id_sel  (p0_id_sel),
        .p0_seg_id  (p0_seg_id),
        .p0_addr    (p0_addr),
        .p0_wdata   (p0_wdata),
        .p0_gnt     (p0_gnt),
        .p0_rvalid  (p0_rvalid),
        .p0_rdata   (p0_rdata),
        .p1_req     (p1_req),
        .p1_we      (p1_we),
        .p1_id_sel  (p1_id_sel),
        .p1_seg_id  (p1_seg_id),
        .p1_addr    (p1_addr),
        .p1_wdata   (p1_wdata),
        .p1_gnt     (p1_gnt),
        .p1_rvalid  (p1_rvalid),
        .p1_rdata   (p1_rdata),
        .mem_cen    (mem_cen),
        .mem_wen    (mem_wen),
        .mem_ren    (mem_ren),
        .mem_id_sel (mem_id_sel),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_seg_id (mem_seg_id),
        .mem_rdata  (mem_rdata)
    );

    // Behavioural spram: samples at the clock edge, rdata gated by ren.
    logic [WIDTH-1:0] ram [0:4095] = '{default: '0};
    logic [WIDTH-1:0] ram_q = '0;
    always @(posedge clk) begin
        if (mem_cen) begin
            if (mem_wen) ram[{mem_id_sel, mem_addr}] <= mem_wdata;
            else if (mem_ren) ram_q <= ram[{mem_id_sel, mem_addr}];
        end
    end
    assign mem_rdata = mem_ren ? ram_q : '0;

    int checks = 0;
    int errors = 0;

    // Reference model: commands in grant order, memory updated at grant time.
    logic [WIDTH-1:0] ref_mem [0:4095] = '{default: '0};
    int               wcnt;
    logic             m1_v, m1_port, m1_we, m1_id;
    logic [1:0]       m1_seg;
    logic [AW-1:0]    m1_addr;
    logic [WIDTH-1:0] m1_wd, m1_rd;
    logic             m2_v, m2_port, m2_id;
    logic [WIDTH-1:0] m2_data;
    logic             s_g0, s_g1;
    logic             auto_drop;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic mdl_reset();
        wcnt = 0;
        m1_v = 0; m1_port = 0; m1_we = 0; m1_id = 0; m1_seg = '0;
        m1_addr = '0; m1_wd = '0; m1_rd = '0;
        m2_v = 0; m2_port = 0; m2_id = 0; m2_data = '0;
    endtask

    task automatic model_check();
        logic c0, c1, e0, e1;
        logic [11:0] idx;
        c0 = !rst && p0_req && !stall && !(m1_v && !m1_we && (m1_id != p0_id_sel));
        c1 = !rst && p1_req && !stall && !(m1_v && !m1_we && (m1_id != p1_id_sel));
        e1 = c1 && !(c0 && (wcnt == int'(MAX_WAIT)));
        e0 = c0 && !e1;
        chk("p0_gnt", 64'(p0_gnt), 64'(e0));
        chk("p1_gnt", 64'(p1_gnt), 64'(e1));
        chk("mem_cen", 64'(mem_cen), 64'(m1_v || m2_v));
        chk("mem_wen", 64'(mem_wen), 64'(m1_v && m1_we));
        chk("mem_ren", 64'(mem_ren), 64'((m1_v && !m1_we) || m2_v));
        chk("mem_id_sel", 64'(mem_id_sel), 64'(m1_v ? m1_id : m2_id));
        chk("mem_addr", 64'(mem_addr), 64'(m1_v ? m1_addr : '0));
        chk("mem_wdata", 64'(mem_wdata), 64'(m1_v ? m1_wd : '0));
        chk("mem_seg_id", 64'(mem_seg_id), 64'(m1_v ? m1_seg : 2'b00));
        chk("p0_rvalid", 64'(p0_rvalid), 64'(m2_v && !m2_port));
        chk("p1_rvalid", 64'(p1_rvalid), 64'(m2_v && m2_port));
        chk("p0_rdata", 64'(p0_rdata), 64'((m2_v && !m2_port) ? m2_data : '0));
        chk("p1_rdata", 64'(p1_rdata), 64'((m2_v && m2_port) ? m2_data : '0));
        s_g0 = p0_gnt;
        s_g1 = p1_gnt;
        if (rst) begin
            mdl_reset();
        end else begin
            if (e0 || !p0_req) wcnt = 0;
            else if (!stall && wcnt < int'(MAX_WAIT)) wcnt++;
            m2_v    = m1_v && !m1_we;
            m2_port = m2_v ? m1_port : 1'b0;
            m2_id   = m2_v ? m1_id : 1'b0;
            m2_data = m1_rd;
            m1_v = e0 || e1;
            m1_port = e1;
            m1_we   = e1 ? p1_we     : (e0 ? p0_we     : 1'b0);
            m1_id   = e1 ? p1_id_sel : (e0 ? p0_id_sel : 1'b0);
            m1_seg  = e1 ? p1_seg_id : (e0 ? p0_seg_id : 2'b00);
            m1_addr = e1 ? p1_addr   : (e0 ? p0_addr   : '0);
            m1_wd   = e1 ? p1_wdata  : (e0 ? p0_wdata  : '0);
            idx = {m1_id, m1_addr};
            m1_rd = '0;
            if (m1_v && m1_we) ref_mem[idx] = m1_wd;
            else if (m1_v) m1_rd = ref_mem[idx];
        end
    endtask

    task automatic step();
        @(negedge clk);
        model_check();
        @(posedge clk);
        #1;
        if (auto_drop) begin
            if (s_g0) p0_req = 1'b0;
            if (s_g1) p1_req = 1'b0;
        end
    endtask

    task automatic drive(input int p, input logic we, input logic id,
                         input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
        if (p == 0) begin
            p0_req = 1; p0_we = we; p0_id_sel = id; p0_addr = a; p0_wdata = d;
            p0_seg_id = {a[0], id};
        end else begin
            p1_req = 1; p1_we = we; p1_id_sel = id; p1_addr = a; p1_wdata = d;
            p1_seg_id = {id, a[0]};
        end
    endtask

    task automatic run_until(input int p, input int maxc, output int waited);
        logic got;
        got = 0;
        waited = 0;
        for (int i = 0; i < maxc && !got; i++) begin
            step();
            waited++;
            got = (p == 0) ? s_g0 : s_g1;
        end
        chk("grant_within_bound", 64'(got), 64'(1));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int first0;
        int n1;
        int ng;
        int waited;
        logic [11:0] g0h;
        logic [11:0] g1h;

        rst = 0; stall = 0; auto_drop = 1;
        p0_req = 0; p0_we = 0; p0_id_sel = 0; p0_seg_id = '0; p0_addr = '0; p0_wdata = '0;
        p1_req = 0; p1_we = 0; p1_id_sel = 0; p1_seg_id = '0; p1_addr = '0; p1_wdata = '0;
        mdl_reset();
        #1 rst = 1;
        p0_req = 1;
        #1;
        chk("rst_mem_cen", 64'(mem_cen), 64'(0));
        chk("rst_mem_ren", 64'(mem_ren), 64'(0));
        chk("rst_p0_gnt", 64'(p0_gnt), 64'(0));
        chk("rst_p0_rvalid", 64'(p0_rvalid), 64'(0));
        @(posedge clk); #1;
        rst = 0; p0_req = 0;

        // Basic write then read
        drive(0, 1, 0, 11'h010, 32'hDEADBEEF); step();
        chk("t1_wr_gnt", 64'(s_g0), 64'(1));
        drive(0, 0, 0, 11'h010, '0); step();
        chk("t1_rd_gnt", 64'(s_g0), 64'(1));
        chk("t1_ren", 64'(mem_ren), 64'(1));
        chk("t1_addr", 64'(mem_addr), 64'(11'h010));
        step();
        chk("t1_rvalid", 64'(p0_rvalid), 64'(1));
        chk("t1_rdata", 64'(p0_rdata), 64'(32'hDEADBEEF));
        chk("t1_p1_rvalid", 64'(p1_rvalid), 64'(0));
        step();

        // Starvation limit with both ports reading continuously
        auto_drop = 0;
        drive(0, 0, 0, 11'h001, '0);
        drive(1, 0, 0, 11'h002, '0);
        first0 = -1; n1 = 0; g0h = '0; g1h = '0;
        for (int i = 0; i < 12; i++) begin
            step();
            g0h[i] = s_g0;
            g1h[i] = s_g1;
            if (s_g0 && first0 < 0) first0 = i;
            if (s_g1 && first0 < 0) n1++;
        end
        chk("t2_first_p0", 64'(first0), 64'(8));
        chk("t2_p1_run", 64'(n1), 64'(8));
        chk("t2_p1_after", 64'(g1h[9]), 64'(1));
        chk("t2_p0_once", 64'(g0h[9]), 64'(0));
        p0_req = 0; p1_req = 0; auto_drop = 1;
        step(); step();

        // Bank turnaround on port 1
        drive(1, 1, 0, 11'h020, 32'h0000A0A0); step();
        drive(1, 1, 1, 11'h020, 32'h0000B1B1); step();
        drive(1, 0, 0, 11'h020, '0); step();
        chk("t3_rd0_gnt", 64'(s_g1), 64'(1));
        drive(1, 0, 1, 11'h020, '0); step();
        chk("t3_bubble", 64'(s_g1), 64'(0));
        chk("t3_rv0", 64'(p1_rvalid), 64'(1));
        chk("t3_rd0", 64'(p1_rdata), 64'(32'h0000A0A0));
        chk("t3_idsel_hold", 64'(mem_id_sel), 64'(0));
        step();
        chk("t3_rd1_gnt", 64'(s_g1), 64'(1));
        step();
        chk("t3_rv1", 64'(p1_rvalid), 64'(1));
        chk("t3_rd1", 64'(p1_rdata), 64'(32'h0000B1B1));
        step();

        // Stall with a read in flight
        drive(0, 0, 1, 11'h020, '0); step();
        chk("t4_rd_gnt", 64'(s_g0), 64'(1));
        stall = 1;
        drive(1, 0, 0, 11'h021, '0);
        drive(0, 0, 0, 11'h022, '0);
        step();
        ng = int'(s_g0) + int'(s_g1);
        chk("t4_rvalid", 64'(p0_rvalid), 64'(1));
        chk("t4_rdata", 64'(p0_rdata), 64'(32'h0000B1B1));
        for (int i = 0; i < 4; i++) begin
            step();
            ng += int'(s_g0) + int'(s_g1);
        end
        chk("t4_no_gnt", 64'(ng), 64'(0));
        stall = 0;
        for (int i = 0; i < 10 && (p0_req || p1_req); i++) step();
        chk("t4_drain", 64'(p0_req || p1_req), 64'(0));
        step(); step();

        // Asynchronous reset while a read is in S1
        drive(0, 0, 0, 11'h010, '0); step();
        chk("t5_gnt", 64'(s_g0), 64'(1));
        #2 rst = 1;
        #1;
        chk("t5_cen_async", 64'(mem_cen), 64'(0));
        chk("t5_ren_async", 64'(mem_ren), 64'(0));
        mdl_reset();
        drive(1, 0, 0, 11'h010, '0);
        step(); step();
        rst = 0;
        run_until(1, 3, waited);
        chk("t5_first_gnt", 64'(waited), 64'(1));
        step();
        chk("t5_rdata", 64'(p1_rdata), 64'(32'hDEADBEEF));
        step();

        // Write to the same bank while a read is returning
        drive(1, 1, 1, 11'h004, 32'h5555AAAA); step();
        drive(0, 0, 1, 11'h004, '0); step();
        chk("t6_rd_gnt", 64'(s_g0), 64'(1));
        drive(1, 1, 1, 11'h005, 32'h00001234); step();
        chk("t6_wr_gnt", 64'(s_g1), 64'(1));
        chk("t6_rdata", 64'(p0_rdata), 64'(32'h5555AAAA));
        chk("t6_wen", 64'(mem_wen), 64'(1));
        chk("t6_ren", 64'(mem_ren), 64'(1));
        drive(0, 0, 1, 11'h005, '0); step();
        chk("t6_rd2_gnt", 64'(s_g0), 64'(1));
        step();
        chk("t6_rd2_data", 64'(p0_rdata), 64'(32'h00001234));
        step();

        // Random traffic on a small address window to force collisions
        for (int i = 0; i < 400; i++) begin
            stall = ($urandom_range(0, 7) == 0);
            if (!p0_req && $urandom_range(0, 2) != 0)
                drive(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      AW'($urandom_range(0, 7)), $urandom);
            if (!p1_req && $urandom_range(0, 2) != 0)
                drive(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      AW'($urandom_range(0, 7)), $urandom);
            step();
        end
        stall = 0;
        for (int i = 0; i < 40 && (p0_req || p1_req); i++) step();
        chk("rand_drain", 64'(p0_req || p1_req), 64'(0));
        step(); step(); step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
